// File: rtl/bus_arbiter_nxm_pkg.sv
// Shared types and helpers for the N x M serial-bus arbiter: FSM states, grant search
// and parameter range checks.
package bus_pkg;

  localparam int MAX_M = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CONNECT = 3'd2,
    BUSY    = 3'd3
  } state_t;

  function automatic bit params_ok(input int nm, input int ns, input int saw);
    return (nm >= 2) && (nm <= MAX_M) && (saw >= 1) && (saw <= 8) &&
           (ns >= 1) && (ns <= (1 << saw));
  endfunction

  // Index of the winning request, or -1. Round-robin starts one past ptr and wraps,
  // so the previous owner is considered last.
  function automatic int pick_index(input logic [MAX_M-1:0] req, input int n,
                                    input logic [2:0] ptr, input logic rr);
    int idx;
    int res;
    res = -1;
    for (int k = 0; k < MAX_M; k++) begin
      if ((k < n) && (res < 0)) begin
        idx = rr ? ((int'(ptr) + 1 + k) % n) : k;
        if (req[idx]) res = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] oh2idx(input logic [MAX_M-1:0] oh);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < MAX_M; k++) begin
      if (oh[k]) r = r | 3'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_arbiter_nxm_if.sv
// Master-side and slave-side signal bundle of the arbiter. "master" is the view of the
// port agents (they drive requests and slave responses); "slave" is the arbiter's view.
interface bus_arbiter_nxm_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  logic [NUM_MASTERS-1:0] m_request, m_addr_valid, m_address, m_data;
  logic [NUM_MASTERS-1:0] m_valid, m_write_en, m_burst;
  logic [NUM_MASTERS-1:0] m_grant, m_data_out, m_ready, m_valid_in, m_error;
  logic [NUM_SLAVES-1:0]  s_data_in, s_ready, s_valid_out, s_split;
  logic [NUM_SLAVES-1:0]  s_sel, s_address, s_data, s_valid, s_write_en, s_burst;

  modport master (
    output m_request, m_addr_valid, m_address, m_data, m_valid, m_write_en, m_burst,
    output s_data_in, s_ready, s_valid_out, s_split,
    input  m_grant, m_data_out, m_ready, m_valid_in, m_error,
    input  s_sel, s_address, s_data, s_valid, s_write_en, s_burst
  );

  modport slave (
    input  m_request, m_addr_valid, m_address, m_data, m_valid, m_write_en, m_burst,
    input  s_data_in, s_ready, s_valid_out, s_split,
    output m_grant, m_data_out, m_ready, m_valid_in, m_error,
    output s_sel, s_address, s_data, s_valid, s_write_en, s_burst
  );
endinterface

// File: rtl/bus_arbiter_nxm_rr_picker.sv
// Request vector + pointer -> one-hot grant; fixed priority (lowest index) when RR=0.
module bus_rr_picker
  import bus_pkg::*;
#(
  parameter int N  = 2,
  parameter bit RR = 1'b1
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_o
);

  logic [MAX_M-1:0] req_pad;
  int               win;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req_i;
    win              = pick_index(req_pad, N, ptr_i, RR);
    gnt_o            = '0;
    for (int k = 0; k < N; k++) begin
      gnt_o[k] = (win == k);
    end
  end

endmodule

// File: rtl/bus_arbiter_nxm.sv
// N-master x M-slave serial-bus arbiter/crossbar: one routed transaction at a time,
// with split parking and resume of the parked owner.
module bus_arbiter_nxm
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SADDR_W     = 2,
  parameter int RR_EN       = 1
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_nxm_if.slave bus,
  output logic [2:0]       state
);

  localparam int NM    = NUM_MASTERS;
  localparam int NS    = NUM_SLAVES;
  localparam int CNT_W = $clog2(SADDR_W + 1);

  if (!params_ok(NUM_MASTERS, NUM_SLAVES, SADDR_W)) begin : g_param_check
    $error("bus_arbiter_nxm: parameter out of range");
  end

  state_t             state_q;
  logic [NM-1:0]      grant_q, parked_q, err_q;
  logic [NS-1:0]      sel_q;
  logic [SADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [2:0]         rr_ptr_q;
  logic [SADDR_W-1:0] park_idx_q [NM];

  logic [NM-1:0]      eligible, new_gnt, resume_cand, resume_gnt, split_of_parked;
  logic [NS-1:0]      idx_oh;
  logic [SADDR_W-1:0] resume_idx;
  logic [MAX_M-1:0]   grant_pad;
  logic [2:0]         owner_idx;
  logic               own_req, own_valid, own_addr, last_bit, idx_oob, idx_ready, cur_split;

  assign own_req   = |(bus.m_request & grant_q);
  assign own_valid = |(bus.m_valid & grant_q);
  assign own_addr  = |(bus.m_address & grant_q);
  assign addr_d    = SADDR_W'({addr_q, own_addr});
  assign last_bit  = (bitcnt_q == CNT_W'(SADDR_W - 1));
  assign idx_oob   = (int'(addr_q) >= NS);
  assign idx_ready = |(bus.s_ready & idx_oh);
  assign cur_split = |(bus.s_split & sel_q);
  // The current owner never competes against itself when a split lets someone else in.
  assign eligible  = bus.m_request & bus.m_addr_valid & ~parked_q & ~grant_q;

  always_comb begin
    idx_oh          = '0;
    split_of_parked = '0;
    resume_idx      = '0;
    grant_pad       = '0;
    grant_pad[NM-1:0] = grant_q;
    owner_idx       = oh2idx(grant_pad);
    for (int j = 0; j < NS; j++) begin
      idx_oh[j] = (int'(addr_q) == j);
    end
    for (int i = 0; i < NM; i++) begin
      for (int j = 0; j < NS; j++) begin
        if (int'(park_idx_q[i]) == j) split_of_parked[i] = split_of_parked[i] | bus.s_split[j];
      end
      if (resume_gnt[i]) resume_idx = park_idx_q[i];
    end
  end

  assign resume_cand = parked_q & ~split_of_parked & bus.m_request;

  bus_rr_picker #(.N(NM), .RR(RR_EN != 0)) u_new_pick (
    .req_i (eligible),
    .ptr_i (rr_ptr_q),
    .gnt_o (new_gnt)
  );

  bus_rr_picker #(.N(NM), .RR(1'b0)) u_resume_pick (
    .req_i (resume_cand),
    .ptr_i (3'd0),
    .gnt_o (resume_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      parked_q <= '0;
      addr_q   <= '0;
      bitcnt_q <= '0;
      rr_ptr_q <= '0;
      err_q    <= '0;
    end else begin
      err_q    <= '0;
      // A parked master that withdraws its request simply forgets its parked slot.
      parked_q <= parked_q & bus.m_request;
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            grant_q  <= new_gnt;
            addr_q   <= '0;
            bitcnt_q <= '0;
            state_q  <= ADDR;
          end
        end
        ADDR: begin
          if (!own_req) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (own_valid) begin
            addr_q   <= addr_d;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (last_bit) state_q <= CONNECT;
          end
        end
        CONNECT: begin
          if (!own_req) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (idx_oob) begin
            err_q   <= grant_q;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (idx_ready) begin
            sel_q   <= idx_oh;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!own_req) begin
            rr_ptr_q <= owner_idx;
            sel_q    <= '0;
            if (|resume_gnt) begin
              grant_q  <= resume_gnt;
              parked_q <= parked_q & bus.m_request & ~resume_gnt;
              addr_q   <= resume_idx;
              state_q  <= CONNECT;
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end else if (cur_split && (|eligible)) begin
            parked_q <= (parked_q | grant_q) & bus.m_request;
            for (int i = 0; i < NM; i++) begin
              if (grant_q[i]) park_idx_q[i] <= addr_q;
            end
            sel_q    <= '0;
            grant_q  <= new_gnt;
            addr_q   <= '0;
            bitcnt_q <= '0;
            state_q  <= ADDR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic busy;
  assign busy  = (state_q == BUSY);
  assign state = state_q;

  // Pure combinational crossbar: grant_q picks the master, sel_q picks the slave.
  assign bus.m_grant    = grant_q;
  assign bus.m_error    = err_q;
  assign bus.m_data_out = grant_q & {NM{|(bus.s_data_in & sel_q)}};
  assign bus.m_ready    = grant_q & {NM{|(bus.s_ready & sel_q)}};
  assign bus.m_valid_in = grant_q & {NM{|(bus.s_valid_out & sel_q)}};

  assign bus.s_sel      = sel_q;
  assign bus.s_address  = sel_q & {NS{own_addr}};
  assign bus.s_data     = sel_q & {NS{|(bus.m_data & grant_q)}};
  assign bus.s_valid    = sel_q & {NS{own_valid & busy}};
  assign bus.s_write_en = sel_q & {NS{|(bus.m_write_en & grant_q)}};
  assign bus.s_burst    = sel_q & {NS{|(bus.m_burst & grant_q)}};

endmodule

// File: tb/tb_bus_arbiter_nxm.sv
// Bench for bus_arbiter_nxm (2 masters, 3 slaves, 2-bit serial slave index, round-robin).
module tb_bus_arbiter_nxm;
  import bus_pkg::*;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;

  always #5 clk = ~clk;

  bus_arbiter_nxm_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus ();

  bus_arbiter_nxm #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SADDR_W(SW), .RR_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of connection / error events, in the order they must appear.
  typedef struct packed {
    logic [NM-1:0] grant;
    logic [NS-1:0] sel;
    logic [NM-1:0] err;
  } ev_t;

  ev_t           sb_q[$];
  ev_t           mon_e;
  logic [NS-1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (((bus.s_sel != '0) && (bus.s_sel != prev_sel)) || (bus.m_error != '0)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: grant %0h sel %0h err %0h with no event expected",
                 bus.m_grant, bus.s_sel, bus.m_error);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_grant", bus.m_grant, mon_e.grant);
        chk("sb_sel",   bus.s_sel,   mon_e.sel);
        chk("sb_err",   bus.m_error, mon_e.err);
      end
    end
    prev_sel <= bus.s_sel;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_request    = '0;
    bus.m_addr_valid = '0;
    bus.m_address    = '0;
    bus.m_data       = '0;
    bus.m_valid      = '0;
    bus.m_write_en   = '0;
    bus.m_burst      = '0;
    bus.s_data_in    = '0;
    bus.s_ready      = '1;
    bus.s_valid_out  = '0;
    bus.s_split      = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic shift_addr(input logic [NM-1:0] mo, input logic [SW-1:0] a);
    for (int b = SW - 1; b >= 0; b--) begin
      bus.m_valid   = mo;
      bus.m_address = a[b] ? mo : '0;
      step();
    end
    bus.m_valid   = '0;
    bus.m_address = '0;
  endtask

  typedef struct {
    int            m;
    int            addr;
    int            rdy_delay;
    logic [NS-1:0] exp_sel;
    logic [NM-1:0] exp_err;
  } vec_t;

  task automatic run_txn(input vec_t v);
    logic [NM-1:0] mo;
    mo = NM'(1) << v.m;
    if (v.exp_err != '0) sb_q.push_back('{grant: '0, sel: '0, err: v.exp_err});
    else                 sb_q.push_back('{grant: mo, sel: v.exp_sel, err: '0});
    if (v.rdy_delay > 0) bus.s_ready = ~v.exp_sel;
    bus.m_request    = mo;
    bus.m_addr_valid = mo;
    step();
    chk("txn_grant", bus.m_grant, mo);
    chk("txn_addr_state", state, ADDR);
    bus.m_addr_valid = '0;
    shift_addr(mo, SW'(v.addr));
    chk("txn_connect_state", state, CONNECT);
    chk("txn_no_sel_yet", bus.s_sel, '0);
    if (v.exp_err != '0) begin
      step();
      chk("err_pulse", bus.m_error, v.exp_err);
      chk("err_state", state, IDLE);
      chk("err_grant", bus.m_grant, '0);
      chk("err_sel", bus.s_sel, '0);
      step();
      chk("err_one_cycle", bus.m_error, '0);
      bus.m_request = '0;
    end else begin
      for (int c = 0; c < v.rdy_delay; c++) begin
        bus.m_valid = mo;
        step();
        chk("wait_state", state, CONNECT);
        chk("wait_s_valid", bus.s_valid, '0);
        chk("wait_s_sel", bus.s_sel, '0);
      end
      bus.m_valid = '0;
      bus.s_ready = '1;
      step();
      chk("conn_sel", bus.s_sel, v.exp_sel);
      chk("conn_state", state, BUSY);
      bus.m_data     = mo;
      bus.m_valid    = mo;
      bus.m_write_en = mo;
      bus.m_burst    = mo;
      bus.m_address  = mo;
      #1;
      chk("route_s_data", bus.s_data, v.exp_sel);
      chk("route_s_valid", bus.s_valid, v.exp_sel);
      chk("route_s_we", bus.s_write_en, v.exp_sel);
      chk("route_s_burst", bus.s_burst, v.exp_sel);
      chk("route_s_addr", bus.s_address, v.exp_sel);
      bus.s_data_in   = v.exp_sel;
      bus.s_valid_out = v.exp_sel;
      #1;
      chk("route_m_data", bus.m_data_out, mo);
      chk("route_m_valid", bus.m_valid_in, mo);
      chk("route_m_ready", bus.m_ready, mo);
      clear_inputs();
      step();
      chk("rel_state", state, IDLE);
      chk("rel_grant", bus.m_grant, '0);
      chk("rel_sel", bus.s_sel, '0);
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 1, 0, 3'b010, 2'b00};
    vecs[1] = '{1, 0, 0, 3'b001, 2'b00};
    vecs[2] = '{0, 3, 0, 3'b000, 2'b01};
    vecs[3] = '{1, 2, 0, 3'b100, 2'b00};
    vecs[4] = '{1, 1, 5, 3'b010, 2'b00};
    vecs[5] = '{1, 3, 0, 3'b000, 2'b10};

    apply_reset();
    chk("rst_state", state, IDLE);
    chk("rst_grant", bus.m_grant, '0);
    chk("rst_sel", bus.s_sel, '0);
    chk("rst_err", bus.m_error, '0);
    chk("rst_s_valid", bus.s_valid, '0);
    chk("rst_m_data_out", bus.m_data_out, '0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Round-robin: pointer starts at 0, so m1 wins a tie; after m1 releases, m0 wins.
    apply_reset();
    sb_q.push_back('{grant: 2'b10, sel: 3'b001, err: '0});
    bus.m_request    = '1;
    bus.m_addr_valid = '1;
    step();
    chk("rr_first", bus.m_grant, 2'b10);
    shift_addr(2'b10, 2'd0);
    step();
    chk("rr_m1_sel", bus.s_sel, 3'b001);
    bus.m_request = 2'b01;
    step();
    chk("rr_release_state", state, IDLE);
    bus.m_request = '1;
    step();
    chk("rr_second", bus.m_grant, 2'b01);
    bus.m_request = '0;
    step();
    chk("abort_state", state, IDLE);
    chk("abort_grant", bus.m_grant, '0);
    chk("abort_no_err", bus.m_error, '0);

    // Split parking and resume without a new address phase.
    apply_reset();
    sb_q.push_back('{grant: 2'b01, sel: 3'b100, err: '0});
    bus.m_request    = 2'b01;
    bus.m_addr_valid = 2'b01;
    step();
    bus.m_addr_valid = '0;
    shift_addr(2'b01, 2'd2);
    step();
    chk("split_m0_sel", bus.s_sel, 3'b100);
    bus.s_split      = 3'b100;
    bus.m_request    = 2'b11;
    bus.m_addr_valid = 2'b10;
    step();
    chk("split_new_grant", bus.m_grant, 2'b10);
    chk("split_state", state, ADDR);
    chk("split_sel_drop", bus.s_sel, '0);
    bus.m_addr_valid = '0;
    sb_q.push_back('{grant: 2'b10, sel: 3'b001, err: '0});
    shift_addr(2'b10, 2'd0);
    step();
    chk("split_m1_sel", bus.s_sel, 3'b001);
    bus.s_split   = '0;
    bus.m_request = 2'b01;
    sb_q.push_back('{grant: 2'b01, sel: 3'b100, err: '0});
    step();
    chk("resume_state", state, CONNECT);
    chk("resume_grant", bus.m_grant, 2'b01);
    chk("resume_sel_low", bus.s_sel, '0);
    step();
    chk("resume_sel", bus.s_sel, 3'b100);
    chk("resume_busy", state, BUSY);
    bus.m_request = '0;
    step();
    chk("resume_release", state, IDLE);

    // Reset in the middle of a routed transfer.
    apply_reset();
    sb_q.push_back('{grant: 2'b01, sel: 3'b010, err: '0});
    bus.m_request    = 2'b01;
    bus.m_addr_valid = 2'b01;
    step();
    bus.m_addr_valid = '0;
    shift_addr(2'b01, 2'd1);
    step();
    chk("mid_busy_sel", bus.s_sel, 3'b010);
    bus.m_data      = 2'b01;
    bus.m_valid     = 2'b01;
    bus.m_address   = 2'b01;
    bus.s_data_in   = '1;
    bus.s_valid_out = '1;
    #1;
    chk("mid_busy_s_data", bus.s_data, 3'b010);
    reset = 1'b1;
    step();
    chk("mid_rst_state", state, IDLE);
    chk("mid_rst_grant", bus.m_grant, '0);
    chk("mid_rst_sel", bus.s_sel, '0);
    chk("mid_rst_s_data", bus.s_data, '0);
    chk("mid_rst_s_valid", bus.s_valid, '0);
    chk("mid_rst_s_addr", bus.s_address, '0);
    chk("mid_rst_m_data", bus.m_data_out, '0);
    chk("mid_rst_m_valid", bus.m_valid_in, '0);
    chk("mid_rst_m_ready", bus.m_ready, '0);
    chk("mid_rst_err", bus.m_error, '0);
    reset = 1'b0;
    clear_inputs();
    step();
    step();

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
